wb_copy_master: RTL
===================

# wb_copy_master

Wishbone B3 bus master that copies a block of 32-bit words from a source address to a destination address, using incrementing-address bursts. It is the initiator counterpart of the multi-port memory slave and plugs into one of that memory's master ports (wbmN_*). It gives the system a memory-to-memory copy engine without a CPU in the loop. Data is staged through a small internal FIFO, one burst-sized chunk at a time.

## Interface
Parameters:
- `dw`, 32: data width; fixed at 32 in this revision.
- `aw`, 32: address width.
- `lw`, 16: width of the length field, in words.
- `burst`, 8: maximum beats per bus burst; power of two, range 2–16.

Ports:
- `wb_clk_i`  in  1  single clock
- `wb_rst_i`  in  1  reset; asynchronous, active-high
- `cmd_start_i`  in  1  one-cycle start strobe; ignored while `busy_o`=1
- `cmd_src_i`  in  aw  source byte address; bits [1:0] are ignored
- `cmd_dst_i`  in  aw  destination byte address; bits [1:0] are ignored
- `cmd_len_i`  in  lw  copy length in words
- `busy_o`  out  1  a command is in progress
- `done_o`  out  1  one-cycle pulse when a command ends (success or error)
- `err_o`  out  1  sticky error flag; cleared by the next accepted start
- `wbm_adr_o`  out  aw  bus address
- `wbm_bte_o`  out  2  burst type extension; always 2'b00 (linear)
- `wbm_cti_o`  out  3  cycle type identifier
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  bus cycle, strobe, write enable
- `wbm_sel_o`  out  4  byte selects; always 4'hf
- `wbm_dat_o`  out  dw  write data
- `wbm_dat_i`  in  dw  read data
- `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i`  in  1 each  slave responses

## Operation
States: IDLE, READ, GAP, WRITE, NEXT.

- **IDLE**
  - A start strobe latches `src` and `dst` with bits [1:0] forced to 0, latches `len`, and clears `err_o`.
  - If `len`=0: `done_o` pulses the next cycle and the block stays in IDLE.
  - Otherwise: `chunk` = min(remaining, `burst`) and the block moves to READ.
- **READ**
  - Drives `cyc`=`stb`=1, `we`=0.
  - `cti`=3'b010 on every beat except the last beat of the chunk, which uses 3'b111. A chunk of one beat uses 3'b111 only.
  - On each ack: push `wbm_dat_i` into the FIFO, add 4 to `src`, decrement the beat count.
  - After the last ack, go to GAP.
- **GAP**
  - One cycle with `cyc`=0, then go to WRITE.
- **WRITE**
  - Drives `we`=1, `wbm_dat_o` = FIFO head, same `cti` rule as READ.
  - On each ack: pop the FIFO, add 4 to `dst`.
  - After the last ack, go to NEXT.
- **NEXT**
  - Subtract `chunk` from remaining.
  - If remaining is 0: pulse `done_o` and return to IDLE.
  - Otherwise: recompute `chunk` and go to READ. `cyc` stays 0 during this cycle.
- **Ack pacing:** the master holds `stb`, `adr`, and `dat` stable until ack. It never assumes acks arrive back-to-back; a slave that acks on alternate cycles must work.
- **Retry (`rty`):** the beat is not counted. Drop `cyc` for one cycle, then re-issue the same address with the same `cti`.
- **Error (`err`):**
  - Drop `cyc` in the next cycle.
  - Set `err_o`=1 and pulse `done_o`.
  - Flush the FIFO and go to IDLE.
- **Simultaneous responses:** if `ack` and `err` are asserted together, `err` wins.
- **Address wrap:** addresses wrap modulo 2^aw with no error.

## Timing
- **Reset values:**
  - All outputs 0, `cti`=3'b000, `bte`=2'b00, `sel`=4'hf, state IDLE.
  - FIFO empty, `err_o`=0.
- **Reset mid-operation:** `cyc` drops asynchronously and the command is discarded; `done_o` does not pulse.
- **Start latency:** start strobe in cycle 0 gives `cyc`/`stb` high in cycle 1, with `wbm_adr_o`=`src`.
- **Beat rate:** one beat per cycle when the slave acks every cycle.
- **Chunk turnaround:** one GAP cycle between the read and write bursts of a chunk, and one NEXT cycle between chunks.
- **Completion:** `done_o` is high in the cycle after the final write ack. `busy_o` falls in that same cycle.
- **Command inputs:** sampled only in the start cycle.
- **FIFO bounds:** can never overflow, because `chunk` ≤ `burst` = FIFO depth. Reading an empty FIFO in WRITE is a design error; assert on it in simulation.

## Structure
- Shared package `wb_pkg` holds:
  - CTI constants: CLASSIC=3'b000, INCR=3'b010, EOB=3'b111.
  - BTE constant: LINEAR=2'b00.
  - The state encoding for this block.
- Sub-module `wb_copy_fifo`:
  - Synchronous FIFO of depth `burst`, width `dw`.
  - Ports: push, pop, flush, `dat_i`, `dat_o`, empty, full.
  - Async reset on `wb_rst_i`.

## Test plan
- **Zero length:** `len`=0 → no `cyc`, `done_o` pulses in cycle 1, `err_o`=0.
- **Single word:** `len`=1, src 0x100 holding 0xDEADBEEF, dst 0x200.
  - Expect a read at 0x100 with `cti`=111, then a write at 0x200 with `cti`=111.
  - Memory 0x200 reads back 0xDEADBEEF.
- **Multi-chunk copy:** `len`=11, `burst`=8, against the memory slave acking on alternate cycles.
  - Expect chunks of 8 then 3 beats.
  - CTI sequence: 010×7 then 111; then 010×2 then 111.
  - All 11 words match; `done_o` pulses once.
- **Error mid-read:** `err` on the 3rd read beat.
  - No writes issued, `err_o`=1, `done_o` pulses.
  - A new start clears `err_o`.
- **Retry:** `rty` on write beat 2.
  - The same address is re-issued after a 1-cycle `cyc` drop.
  - Data is correct and the total ack count is unchanged.
- **Disturbances:**
  - `cmd_start_i` while busy is ignored.
  - `wb_rst_i` mid-WRITE forces all outputs to reset values immediately, with no `done_o`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the copy master.
// Holds the cycle-type / burst-type encodings and the copy engine state encoding.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StGap,
    StWrite,
    StNext
  } copy_state_t;

  // Incrementing burst: every beat is INCR except the final one, which is end-of-burst.
  function automatic logic [2:0] beat_cti(input logic last_beat);
    return last_beat ? CTI_EOB : CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_copy_fifo.sv
// Staging FIFO for one burst-sized chunk of the copy engine.
// Ports:
//   wb_clk_i, wb_rst_i  clock and asynchronous active-high reset
//   push_i, dat_i       write a word
//   pop_i, dat_o        discard the head word; dat_o always shows the head
//   flush_i             empty the FIFO (takes priority over push/pop)
//   empty_o, full_o     occupancy flags
module wb_copy_fifo #(
  parameter int unsigned depth = 8,
  parameter int unsigned dw    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [dw-1:0] dat_i,
  output logic [dw-1:0] dat_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned PW = $clog2(depth);

  logic [dw-1:0] r_mem [depth];
  // One extra pointer bit distinguishes full from empty.
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_i && !flush_i) r_mem[r_wr_ptr[PW-1:0]] <= dat_i;
  end

  assign dat_o   = r_mem[r_rd_ptr[PW-1:0]];
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone B3 memory-to-memory copy master.
// Copies cmd_len_i words from cmd_src_i to cmd_dst_i, one chunk of up to `burst` words at a
// time: an incrementing read burst fills the staging FIFO, one idle cycle, then an
// incrementing write burst drains it.
// Ports:
//   wb_clk_i, wb_rst_i             clock, asynchronous active-high reset
//   cmd_start_i/src/dst/len        command strobe and operands (sampled on the start cycle)
//   busy_o, done_o, err_o          status: in progress, end-of-command pulse, sticky error
//   wbm_*                          Wishbone master bus
module wb_copy_master
  import wb_pkg::*;
#(
  parameter int unsigned dw    = 32,
  parameter int unsigned aw    = 32,
  parameter int unsigned lw    = 16,
  parameter int unsigned burst = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_start_i,
  input  logic [aw-1:0] cmd_src_i,
  input  logic [aw-1:0] cmd_dst_i,
  input  logic [lw-1:0] cmd_len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wbm_adr_o,
  output logic [1:0]    wbm_bte_o,
  output logic [2:0]    wbm_cti_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [dw-1:0] wbm_dat_o,
  input  logic [dw-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic          wbm_rty_i
);

  copy_state_t   r_state;
  logic [aw-1:0] r_src;
  logic [aw-1:0] r_dst;
  logic [aw-1:0] r_adr;
  logic [lw-1:0] r_rem;
  logic [lw-1:0] r_chunk;
  logic [lw-1:0] r_beats;
  logic [2:0]    r_cti;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_active;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [dw-1:0] w_fifo_dat;
  logic [lw-1:0] w_rem_left;
  logic [lw-1:0] w_first_chunk;
  logic [lw-1:0] w_next_chunk;

  function automatic logic [lw-1:0] f_chunk(input logic [lw-1:0] rem);
    return (rem > lw'(burst)) ? lw'(burst) : rem;
  endfunction

  assign w_active      = r_cyc & r_stb;
  // err outranks a simultaneous ack, so neither push nor pop happens on an error beat.
  assign w_push        = (r_state == StRead)  && w_active && wbm_ack_i && !wbm_err_i;
  assign w_pop         = (r_state == StWrite) && w_active && wbm_ack_i && !wbm_err_i;
  assign w_flush       = w_active && wbm_err_i;
  assign w_rem_left    = r_rem - r_chunk;
  assign w_first_chunk = f_chunk(cmd_len_i);
  assign w_next_chunk  = f_chunk(w_rem_left);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_adr   <= '0;
      r_rem   <= '0;
      r_chunk <= '0;
      r_beats <= '0;
      r_cti   <= CTI_CLASSIC;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cmd_start_i) begin
            r_src <= cmd_src_i & ~aw'(3);
            r_dst <= cmd_dst_i & ~aw'(3);
            r_rem <= cmd_len_i;
            r_err <= 1'b0;
            if (cmd_len_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_chunk <= w_first_chunk;
              r_beats <= w_first_chunk;
              r_adr   <= cmd_src_i & ~aw'(3);
              r_cti   <= beat_cti(w_first_chunk == lw'(1));
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= StRead;
            end
          end
        end

        StRead, StWrite: begin
          if (!r_cyc) begin
            // Cycle was dropped for a retry: re-issue the same beat unchanged.
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
          end else if (wbm_err_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_cti   <= CTI_CLASSIC;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (wbm_ack_i) begin
            r_beats <= r_beats - lw'(1);
            if (r_state == StRead) r_src <= r_src + aw'(4);
            else                   r_dst <= r_dst + aw'(4);
            if (r_beats == lw'(1)) begin
              r_cyc <= 1'b0;
              r_stb <= 1'b0;
              r_we  <= 1'b0;
              r_cti <= CTI_CLASSIC;
              if (r_state == StRead) begin
                r_state <= StGap;
              end else if (w_rem_left == '0) begin
                // Final chunk: finish straight from the last ack so done_o lands one
                // cycle after it, rather than spending a NEXT cycle first.
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end else begin
                r_state <= StNext;
              end
            end else begin
              r_adr <= r_adr + aw'(4);
              r_cti <= beat_cti(r_beats == lw'(2));
            end
          end else if (wbm_rty_i) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
          end
        end

        StGap: begin
          r_beats <= r_chunk;
          r_adr   <= r_dst;
          r_cti   <= beat_cti(r_chunk == lw'(1));
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= 1'b1;
          r_state <= StWrite;
        end

        StNext: begin
          r_rem   <= w_rem_left;
          r_chunk <= w_next_chunk;
          r_beats <= w_next_chunk;
          r_adr   <= r_src;
          r_cti   <= beat_cti(w_next_chunk == lw'(1));
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_we    <= 1'b0;
          r_state <= StRead;
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  wb_copy_fifo #(
    .depth (burst),
    .dw    (dw)
  ) u_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .push_i   (w_push),
    .pop_i    (w_pop),
    .flush_i  (w_flush),
    .dat_i    (wbm_dat_i),
    .dat_o    (w_fifo_dat),
    .empty_o  (w_fifo_empty),
    .full_o   (w_fifo_full)
  );

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign wbm_adr_o = r_adr;
  assign wbm_bte_o = BTE_LINEAR;
  assign wbm_cti_o = r_cti;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = 4'hf;
  assign wbm_dat_o = r_we ? w_fifo_dat : '0;

  // A chunk never exceeds the FIFO depth and every write beat was read first.
  a_no_underflow : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
                                    !(w_pop && w_fifo_empty));
  a_no_overflow  : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
                                    !(w_push && w_fifo_full));

endmodule
